mod_mul_seq: RTL and testbench

MOD_MUL_SEQ -- requirements
Module: mod_mul_seq

---
 rtl/mod_mul_seq.sv | 172 +++++++++++++++++
 tb/tb_mod_mul_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_seq.sv
// Sequential modular multiplier: MSB-first double-and-add over an
// external modular adder/subtractor, with optional negated result.
module mod_mul_seq #(
   parameter int WIDTH = 4,
   parameter int MOD   = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_neg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_z,
   output logic             out_err,
   output logic [WIDTH-1:0] op_x,
   output logic [WIDTH-1:0] op_y,
   output logic             op_s,
   input  logic [WIDTH-1:0] op_z
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH:0] MOD_L = (WIDTH+1)'(MOD);
   localparam logic [IW-1:0] I_TOP = IW'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      DBL,
      ADD,
      NEG,
      DONE
   } state_t;

   state_t           state_q;
   state_t           exit_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             neg_q;
   logic [WIDTH-1:0] acc_q;
   logic [IW-1:0]    i_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_z_q;
   logic             out_err_q;
   logic             range_err;
   logic             last_bit;

   assign range_err = ({1'b0, in_a} >= MOD_L) ||
                      ({1'b0, in_b} >= MOD_L);
   assign last_bit  = (i_q == '0);

   // Where to go once the current bit (double, plus optional add) is done
   always_comb begin
      exit_d = DONE;
      if (!last_bit) begin
         exit_d = DBL;
      end else if (neg_q) begin
         exit_d = NEG;
      end
   end

   always_comb begin
      op_x = '0;
      op_y = '0;
      op_s = 1'b0;
      unique case (state_q)
         DBL: begin
            op_x = acc_q;
            op_y = acc_q;
         end
         ADD: begin
            op_x = acc_q;
            op_y = a_q;
         end
         NEG: begin
            op_y = acc_q;
            op_s = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         neg_q       <= 1'b0;
         acc_q       <= '0;
         i_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_z_q     <= '0;
         out_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  neg_q      <= in_neg;
                  acc_q      <= '0;
                  i_q        <= I_TOP;
                  in_ready_q <= 1'b0;
                  if (range_err) begin
                     state_q     <= DONE;
                     out_valid_q <= 1'b1;
                     out_z_q     <= '0;
                     out_err_q   <= 1'b1;
                  end else begin
                     state_q   <= DBL;
                     out_err_q <= 1'b0;
                  end
               end
            end
            DBL: begin
               acc_q <= op_z;
               if (b_q[i_q]) begin
                  state_q <= ADD;
               end else begin
                  state_q <= exit_d;
                  if (!last_bit) begin
                     i_q <= i_q - 1'b1;
                  end
                  if (exit_d == DONE) begin
                     out_valid_q <= 1'b1;
                     out_z_q     <= op_z;
                  end
               end
            end
            ADD: begin
               acc_q   <= op_z;
               state_q <= exit_d;
               if (!last_bit) begin
                  i_q <= i_q - 1'b1;
               end
               if (exit_d == DONE) begin
                  out_valid_q <= 1'b1;
                  out_z_q     <= op_z;
               end
            end
            NEG: begin
               acc_q       <= op_z;
               state_q     <= DONE;
               out_valid_q <= 1'b1;
               out_z_q     <= op_z;
            end
            DONE: begin
               if (out_ready) begin
                  state_q     <= IDLE;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  out_z_q     <= '0;
                  out_err_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_z     = out_z_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_mod_mul_seq.sv
// Directed bench for mod_mul_seq with a behavioural modular adder.
module tb_mod_mul_seq;

   localparam int W = 4;
   localparam int M = 15;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_neg;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_z;
   logic         out_err;
   logic [W-1:0] op_x;
   logic [W-1:0] op_y;
   logic         op_s;
   logic [W-1:0] op_z;

   int vec = 0;
   int bad = 0;

   mod_mul_seq #(.WIDTH(W), .MOD(M)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_neg(in_neg),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_err(out_err),
      .op_x(op_x), .op_y(op_y), .op_s(op_s), .op_z(op_z)
   );

   always #5 clk = ~clk;

   always_comb begin
      int r;
      r = 0;
      if (op_s) r = (int'(op_x) + M - int'(op_y)) % M;
      else      r = (int'(op_x) + int'(op_y)) % M;
      op_z = W'(r);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_neg = 1'b0;
      tick(); tick();
      vec++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      vec++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      vec++; if (out_z !== '0) begin bad++; $display("FAIL rst_out_z got %0d want 0", out_z); end
      vec++; if (out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got %b want 0", out_err); end
      vec++; if (op_x !== '0 || op_y !== '0 || op_s !== 1'b0) begin
         bad++; $display("FAIL rst_ops got x=%0d y=%0d s=%b want 0 0 0", op_x, op_y, op_s);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic neg, input logic [W-1:0] ez,
                        input int elat, input logic [W-1:0] epre);
      int n;
      int subs;
      logic [W-1:0] sx, sy;
      subs = 0; sx = '0; sy = '0;
      in_a = a; in_b = b; in_neg = neg; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         if (op_s) begin subs++; sx = op_x; sy = op_y; end
         tick(); n++;
      end
      vec++; if (n !== elat) begin
         bad++; $display("FAIL lat a=%0d b=%0d n=%b got %0d want %0d", a, b, neg, n, elat);
      end
      vec++; if (out_z !== ez) begin
         bad++; $display("FAIL z a=%0d b=%0d n=%b got %0d want %0d", a, b, neg, out_z, ez);
      end
      vec++; if (out_err !== 1'b0) begin bad++; $display("FAIL err a=%0d b=%0d got %b want 0", a, b, out_err); end
      vec++; if (subs !== (neg ? 1 : 0)) begin bad++; $display("FAIL subcnt got %0d want %0d", subs, neg ? 1 : 0); end
      if (neg) begin
         vec++; if (sx !== '0 || sy !== epre) begin
            bad++; $display("FAIL negops got x=%0d y=%0d want 0 %0d", sx, sy, epre);
         end
      end
      vec++; if (in_ready !== 1'b0) begin bad++; $display("FAIL done_in_ready got %b want 0", in_ready); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL release got v=%b r=%b want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_mul();
      do_op(4'd7, 4'd5, 1'b0, 4'd5, 6, 4'd0);
      do_op(4'd9, 4'd0, 1'b0, 4'd0, 4, 4'd0);
      do_op(4'd14, 4'd14, 1'b0, 4'd1, 7, 4'd0);
   endtask

   task automatic test_neg();
      do_op(4'd7, 4'd5, 1'b1, 4'd10, 7, 4'd5);
      do_op(4'd3, 4'd0, 1'b1, 4'd0, 5, 4'd0);
   endtask

   task automatic test_reset_mid();
      int seen;
      in_a = 4'd7; in_b = 4'd5; in_neg = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL midrst got v=%b r=%b want 0 1", out_valid, in_ready);
      end
      vec++; if (op_x !== '0 || op_y !== '0) begin
         bad++; $display("FAIL midrst_ops got x=%0d y=%0d want 0 0", op_x, op_y);
      end
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out_valid) seen++;
      end
      vec++; if (seen !== 0) begin bad++; $display("FAIL midrst_result got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_backpressure();
      int n;
      in_a = 4'd3; in_b = 4'd2; in_neg = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin tick(); n++; end
      vec++; if (n !== 5) begin bad++; $display("FAIL bp_lat got %0d want 5", n); end
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0]; in_a = 4'd1; in_b = 4'd1;
         tick();
         vec++; if (out_valid !== 1'b1 || out_z !== 4'd6 || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold%0d got v=%b z=%0d r=%b want 1 6 0", k, out_valid, out_z, in_ready);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_release got r=%b v=%b want 1 0", in_ready, out_valid);
      end
      tick(); tick();
      vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_x !== '0) begin
         bad++; $display("FAIL bp_idle got r=%b v=%b x=%0d want 1 0 0", in_ready, out_valid, op_x);
      end
   endtask

   task automatic range_case(input logic [W-1:0] a, input logic [W-1:0] b);
      int busy;
      in_a = a; in_b = b; in_neg = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      vec++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_z !== '0) begin
         bad++; $display("FAIL range a=%0d b=%0d got v=%b e=%b z=%0d want 1 1 0", a, b, out_valid, out_err, out_z);
      end
      busy = 0;
      for (int k = 0; k < 3; k++) begin
         if (op_x !== '0 || op_y !== '0 || op_s !== 1'b0) busy++;
         tick();
      end
      vec++; if (busy !== 0 || out_valid !== 1'b1 || out_err !== 1'b1) begin
         bad++; $display("FAIL range_hold a=%0d b=%0d got busy=%0d v=%b e=%b want 0 1 1", a, b, busy, out_valid, out_err);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vec++; if (out_err !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL range_clr got e=%b r=%b want 0 1", out_err, in_ready);
      end
   endtask

   task automatic test_range();
      range_case(4'd15, 4'd3);
      range_case(4'd2, 4'd15);
      do_op(4'd14, 4'd1, 1'b0, 4'd14, 5, 4'd0);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_neg();
      test_reset_mid();
      test_backpressure();
      test_range();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
